// File: rtl/board_generator_if.sv
// Control and cell-write bundle between the board generator, the top level
// that requests boards, and the initial-board storage it fills.
interface board_generator_if;
    logic        GENERATE;
    logic [4:0]  SIZE;
    logic [3:0]  COLOR_NUM;
    logic [15:0] SEED;
    logic        SEED_LOAD;
    logic        CELL_WE;
    logic [4:0]  CELL_ROW;
    logic [4:0]  CELL_COL;
    logic [2:0]  CELL_COLOR;
    logic        BUSY;
    logic        BOARD_READY;

    modport master (
        input  GENERATE, SIZE, COLOR_NUM, SEED, SEED_LOAD,
        output CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR, BUSY, BOARD_READY
    );

    modport slave (
        output GENERATE, SIZE, COLOR_NUM, SEED, SEED_LOAD,
        input  CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR, BUSY, BOARD_READY
    );
endinterface

// File: rtl/board_generator.sv
// Pseudo-random starting-board generator: walks the board row-major and emits
// one (row, col, colour) write per cycle, colours drawn from a Galois LFSR.
module board_generator #(
    parameter logic [15:0] LFSR_RESET = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS  = 16'hB400,
    parameter int          MAX_SIZE   = 26
) (
    input logic               CLOCK,
    input logic               RESET,
    board_generator_if.master bus
);
    typedef enum logic [1:0] {IDLE, FILL, FIX, DONE} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [4:0]  size_l;
    logic [3:0]  nc;
    logic [2:0]  c0;
    logic        uniform;

    logic        vld_p1;
    logic [4:0]  row_p1;
    logic [4:0]  col_p1;
    logic [2:0]  color_p1;
    logic        busy_p1;
    logic        ready_p1;

    logic [15:0] lfsr_next;
    logic [15:0] lfsr_idle;
    logic [4:0]  size_in;
    logic [3:0]  nc_in;
    logic        first_cell;
    logic        last_col;
    logic        last_cell;
    logic        uniform_now;
    logic [2:0]  c0_now;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [2:0] mod_nc(input logic [3:0] v, input logic [3:0] n);
        logic [3:0] r;
        r = v % n;
        return r[2:0];
    endfunction

    function automatic logic [4:0] sat_size(input logic [4:0] v);
        if (v < 5'd2)
            return 5'd2;
        if (int'(v) > MAX_SIZE)
            return 5'(MAX_SIZE);
        return v;
    endfunction

    function automatic logic [3:0] sat_colors(input logic [3:0] v);
        if (v < 4'd2)
            return 4'd2;
        if (v > 4'd8)
            return 4'd8;
        return v;
    endfunction

    always_comb begin
        lfsr_next = lfsr_step(lfsr);
        lfsr_idle = lfsr_next;
        if (bus.SEED_LOAD)
            lfsr_idle = (bus.SEED == 16'h0000) ? LFSR_RESET : bus.SEED;
        size_in     = sat_size(bus.SIZE);
        nc_in       = sat_colors(bus.COLOR_NUM);
        first_cell  = (row_p1 == 5'd0) && (col_p1 == 5'd0);
        last_col    = (col_p1 == size_l - 5'd1);
        last_cell   = last_col && (row_p1 == size_l - 5'd1);
        c0_now      = first_cell ? color_p1 : c0;
        uniform_now = first_cell || (uniform && (color_p1 == c0));
    end

    // p1: registered cell-write stage, stable for the whole strobe cycle
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            lfsr     <= LFSR_RESET;
            size_l   <= 5'd0;
            nc       <= 4'd0;
            c0       <= 3'd0;
            uniform  <= 1'b0;
            vld_p1   <= 1'b0;
            row_p1   <= 5'd0;
            col_p1   <= 5'd0;
            color_p1 <= 3'd0;
            busy_p1  <= 1'b0;
            ready_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    lfsr <= lfsr_idle;
                    if (bus.GENERATE) begin
                        state    <= FILL;
                        size_l   <= size_in;
                        nc       <= nc_in;
                        uniform  <= 1'b0;
                        vld_p1   <= 1'b1;
                        row_p1   <= 5'd0;
                        col_p1   <= 5'd0;
                        color_p1 <= mod_nc({1'b0, lfsr_idle[2:0]}, nc_in);
                        busy_p1  <= 1'b1;
                        ready_p1 <= 1'b0;
                    end
                end
                FILL: begin
                    lfsr    <= lfsr_next;
                    c0      <= c0_now;
                    uniform <= uniform_now;
                    if (last_cell) begin
                        if (uniform_now) begin
                            // A single-colour board would already be solved.
                            state    <= FIX;
                            row_p1   <= 5'd0;
                            col_p1   <= 5'd1;
                            color_p1 <= mod_nc({1'b0, c0} + 4'd1, nc);
                        end else begin
                            state    <= DONE;
                            vld_p1   <= 1'b0;
                            row_p1   <= 5'd0;
                            col_p1   <= 5'd0;
                            color_p1 <= 3'd0;
                            busy_p1  <= 1'b0;
                            ready_p1 <= 1'b1;
                        end
                    end else begin
                        if (last_col) begin
                            col_p1 <= 5'd0;
                            row_p1 <= row_p1 + 5'd1;
                        end else begin
                            col_p1 <= col_p1 + 5'd1;
                        end
                        color_p1 <= mod_nc({1'b0, lfsr_next[2:0]}, nc);
                    end
                end
                FIX: begin
                    state    <= DONE;
                    vld_p1   <= 1'b0;
                    row_p1   <= 5'd0;
                    col_p1   <= 5'd0;
                    color_p1 <= 3'd0;
                    busy_p1  <= 1'b0;
                    ready_p1 <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CELL_WE     = vld_p1;
    assign bus.CELL_ROW    = row_p1;
    assign bus.CELL_COL    = col_p1;
    assign bus.CELL_COLOR  = color_p1;
    assign bus.BUSY        = busy_p1;
    assign bus.BOARD_READY = ready_p1;
endmodule
